fifo_rr_arbiter: RTL and testbench

- Shares one generic FIFO between NUM_REQ producers using round-robin arbitration.
- Each FIFO entry is tagged with the winning requester ID, so the single consumer knows the source of every popped word.
- Sits between core-side producers (e.g. cache miss / writeback sources) and a shared downstream queue.
- Owns the FIFO instance and the fairness state.

---
 rtl/fifo_rr_arbiter_pkg.sv | 11 +
 rtl/fifo.sv | 72 +++++++
 rtl/fifo_rr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared helpers for the round-robin FIFO arbiter: requester ID width and statistics counter width.
package fifo_rr_arbiter_pkg;

    localparam int unsigned STATS_CNT_W = 16;

    // Width of a requester ID; a single bit is kept even when only one ID exists.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with registered full/not_empty flags and a head-of-queue read port.
module fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             not_empty_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             not_empty_q, not_empty_d;
    logic             do_push, do_pop;

    // Flags come from registers, so a pop never frees space for a push in the same cycle.
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & not_empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        cnt_d       = cnt_q + CW'(do_push) - CW'(do_pop);
        full_d      = (cnt_d == CW'(DEPTH));
        not_empty_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            not_empty_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            not_empty_q <= not_empty_d;
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o     = mem[rd_ptr_q];
    assign not_empty_o = not_empty_q;
    assign full_o      = full_q;

endmodule

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               valid_c_o,
    output logic [ID_W-1:0]    winner_c_o
);

    logic [NUM_REQ-1:0] rot;
    logic [31:0]        sum;

    // Rotate so bit 0 is the requester currently holding priority.
    assign rot = NUM_REQ'({req_i, req_i} >> ptr_i);

    always_comb begin
        valid_c_o  = 1'b0;
        winner_c_o = '0;
        sum        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!valid_c_o && rot[k]) begin
                valid_c_o = 1'b1;
                sum       = 32'(ptr_i) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                winner_c_o = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter feeding one shared FIFO; each entry carries its requester ID.
// Optional per-requester grant counters are built when FIFO_RR_ARBITER_STATS_EN is defined.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned ID_W   = id_w(NUM_REQ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       pop,
    output logic                       not_empty,
    output logic [WIDTH-1:0]           rdata,
    output logic [ID_W-1:0]            rid,
    output logic                       full
`ifdef FIFO_RR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt,
    input  logic                           stats_clr
`endif
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] payload;
    } fifo_rr_entry_t;

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            pick_valid;
    logic [ID_W-1:0] pick_id;
    logic            grant;
    logic            fifo_full;
    fifo_rr_entry_t  wentry;
    fifo_rr_entry_t  rentry;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i      (req),
        .ptr_i      (rr_ptr_q),
        .valid_c_o  (pick_valid),
        .winner_c_o (pick_id)
    );

    // Reset masks the grant so ack drops the moment reset rises.
    assign grant = pick_valid & ~fifo_full & ~reset;
    assign ack   = grant ? (NUM_REQ'(1) << pick_id) : '0;

    always_comb begin
        wentry.id      = pick_id;
        wentry.payload = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                wentry.payload = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    fifo #(
        .WIDTH (ID_W + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (grant),
        .wdata_i     (wentry),
        .pop_i       (pop),
        .rdata_o     (rentry),
        .not_empty_o (not_empty),
        .full_o      (fifo_full)
    );

    assign full  = fifo_full;
    assign rdata = rentry.payload;
    assign rid   = rentry.id;

`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][STATS_CNT_W-1:0] cnt_q, cnt_d;

    // Saturating grant counters; a clear takes precedence over a same-cycle grant.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (stats_clr) begin
                cnt_d[i] = '0;
            end else if (ack[i] && (cnt_q[i] != {STATS_CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + STATS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized and directed bench for fifo_rr_arbiter against a queue-based reference model.
module tb_fifo_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int D   = 4;
    localparam int IDW = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req   = '0;
    logic [N*W-1:0]   req_data = '0;
    logic             pop   = 1'b0;
    logic [N-1:0]     ack;
    logic             not_empty;
    logic [W-1:0]     rdata;
    logic [IDW-1:0]   rid;
    logic             full;
`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [N*16-1:0]  grant_cnt;
    logic             stats_clr = 1'b0;
    int               cnt_m [N];
`endif

    fifo_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .pop       (pop),
        .not_empty (not_empty),
        .rdata     (rdata),
        .rid       (rid),
        .full      (full)
`ifdef FIFO_RR_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stats_clr (stats_clr)
`endif
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {id, data} plus the priority index.
    typedef struct {
        int          id;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   rr_m = 0;

    function automatic int pick();
        if (reset || req == '0 || q.size() >= D) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr_m + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            rr_m = 0;
`ifdef FIFO_RR_ARBITER_STATS_EN
            for (int i = 0; i < N; i++) cnt_m[i] = 0;
`endif
        end else begin
            int w;
            bit popd;
            w    = pick();
            popd = pop && (q.size() > 0);
            if (popd) void'(q.pop_front());
            if (w >= 0) begin
                ent_t e;
                e.id   = w;
                e.data = req_data[w*W +: W];
                q.push_back(e);
                rr_m = (w + 1) % N;
            end
`ifdef FIFO_RR_ARBITER_STATS_EN
            for (int i = 0; i < N; i++) begin
                if (stats_clr) cnt_m[i] = 0;
                else if (w == i && cnt_m[i] < 65535) cnt_m[i] = cnt_m[i] + 1;
            end
`endif
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clock) begin
        int w;
        logic [N-1:0] eack;
        w    = pick();
        eack = (w >= 0) ? (N'(1) << w) : '0;
        chk("ack", 64'(ack), 64'(eack));
        chk("full", 64'(full), 64'(!reset && q.size() == D));
        chk("not_empty", 64'(not_empty), 64'(!reset && q.size() > 0));
        if (!reset && q.size() > 0) begin
            chk("rdata", 64'(rdata), 64'(q[0].data));
            chk("rid", 64'(rid), 64'(q[0].id));
        end
`ifdef FIFO_RR_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(cnt_m[i]));
        end
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        pop   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*W +: W] = d;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        chk("rst_ne", 64'(not_empty), 64'h0);
        chk("rst_full", 64'(full), 64'h0);

        // Single requester, then wrap priority from rr_ptr=3.
        do_reset();
        set_data(2, 32'hA5);
        req = 4'b0100;
        @(negedge clock);
        chk("t1_ack", 64'(ack), 64'h4);
        tick();
        set_data(0, 32'h11);
        set_data(3, 32'h33);
        req = 4'b1001;
        @(negedge clock);
        chk("t1_ne", 64'(not_empty), 64'h1);
        chk("t1_rdata", 64'(rdata), 64'hA5);
        chk("t1_rid", 64'(rid), 64'h2);
        chk("t4_ack_wrap", 64'(ack), 64'h8);
        tick();
        req = 4'b0001;
        @(negedge clock);
        chk("t4_ack_next", 64'(ack), 64'h1);
        tick();
        req = '0;

        // All requesting with a pop every cycle.
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 32'(100 + i));
        req = 4'b1111;
        pop = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("t2_ack_seq", 64'(ack), 64'(N'(1) << (k % N)));
            if (k >= 1) chk("t2_rid_seq", 64'(rid), 64'((k - 1) % N));
            tick();
        end
        req = '0;
        pop = 1'b0;

        // Full back-pressure: grants 0,1,0,1 leave rr_ptr at 2.
        do_reset();
        req = 4'b0011;
        repeat (4) tick();
        @(negedge clock);
        chk("t3_full", 64'(full), 64'h1);
        chk("t3_ack_full", 64'(ack), 64'h0);
        tick();
        pop = 1'b1;
        @(negedge clock);
        chk("t3_ack_pop_cycle", 64'(ack), 64'h0);
        tick();
        pop = 1'b0;
        @(negedge clock);
        chk("t3_ack_after_pop", 64'(ack), 64'h1);
        chk("t3_full_after_pop", 64'(full), 64'h0);
        tick();
        req = '0;

        // Reset with three entries queued and everyone requesting.
        do_reset();
        req = 4'b1111;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_ack_in_reset", 64'(ack), 64'h0);
        chk("t5_ne_in_reset", 64'(not_empty), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t5_first_grant", 64'(ack), 64'h1);
        tick();
        req = '0;

        // Randomized handshake traffic with alternating pop pressure.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] a;
            int pct;
            pct = ((c / 400) % 2 == 1) ? 25 : 85;
            pop = ($urandom_range(0, 99) < pct);
            @(negedge clock);
            a = ack;
            @(posedge clock);
            #1;
            if (c == 1700) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (a[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                    else set_data(i, $urandom);
                end else if (req[i]) begin
                    if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_data(i, $urandom);
                end
            end
        end
        req = '0;
        pop = 1'b0;

`ifdef FIFO_RR_ARBITER_STATS_EN
        // Saturation of requester 1, then clear during a grant.
        do_reset();
        req = 4'b0010;
        pop = 1'b1;
        repeat (70000) tick();
        @(negedge clock);
        chk("t6_sat", 64'(grant_cnt[16 +: 16]), 64'hFFFF);
        tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        @(negedge clock);
        chk("t6_clr", 64'(grant_cnt[16 +: 16]), 64'h0);
        tick();
        req = '0;
        pop = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
